// File: rtl/shift_register_if.sv
// Bus between the SPI-style peripheral sequencer and the shift register datapath.
// The master drives strobes, load and serial input; the slave returns register state.
interface shift_register_if #(
    parameter int width = 8
);
    logic             peripheralClkEdge;
    logic             peripheralClk8Edge;
    logic             parallelLoad;
    logic [width-1:0] parallelDataIn;
    logic             serialDataIn;
    logic [width-1:0] parallelDataOut;
    logic             serialDataOut;
    logic             wordReady;

    modport master (
        output peripheralClkEdge,
        output peripheralClk8Edge,
        output parallelLoad,
        output parallelDataIn,
        output serialDataIn,
        input  parallelDataOut,
        input  serialDataOut,
        input  wordReady
    );

    modport slave (
        input  peripheralClkEdge,
        input  peripheralClk8Edge,
        input  parallelLoad,
        input  parallelDataIn,
        input  serialDataIn,
        output parallelDataOut,
        output serialDataOut,
        output wordReady
    );
endinterface

// File: rtl/shift_register.sv
// Serial/parallel shift register for the SPI-style peripheral datapath.
// Shifts MSB-out on peripheral clock-edge strobes and flags each completed word.
module shift_register #(
    parameter int width = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    shift_register_if.slave       bus
);
    localparam int cntW = $clog2(width + 1);
    localparam logic [cntW-1:0] lastBit = cntW'(width - 1);
    localparam logic [cntW-1:0] cntOne  = cntW'(1);

    logic [width-1:0] mem;
    logic [width-1:0] memNext;
    logic [cntW-1:0]  cnt;
    logic [cntW-1:0]  cntNext;
    logic             ready;
    logic             readyNext;

    always_comb begin
        memNext   = mem;
        cntNext   = cnt;
        readyNext = 1'b0;
        if (bus.peripheralClkEdge) begin
            if (bus.parallelLoad) begin
                memNext = bus.parallelDataIn;
                cntNext = '0;
            end else begin
                memNext = {mem[width-2:0], bus.serialDataIn};
                // A word-boundary strobe makes this shift bit 1 of a fresh word.
                if (bus.peripheralClk8Edge) begin
                    cntNext = cntOne;
                end else if (cnt == lastBit) begin
                    cntNext   = '0;
                    readyNext = 1'b1;
                end else begin
                    cntNext = cnt + cntOne;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            mem   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            mem   <= memNext;
            cnt   <= cntNext;
            ready <= readyNext;
        end
    end

    assign bus.parallelDataOut = mem;
    assign bus.serialDataOut   = mem[width-1];
    assign bus.wordReady       = ready;
endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register (width 8): a reference model queues the
// expected register view per cycle and each scenario pops and compares it.
module tb_shift_register;
    logic clk;
    logic resetN;
    int   total;
    int   bad;

    typedef struct packed {
        logic [7:0] mem;
        logic       sout;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [7:0] mMem;
    logic [3:0] mCnt;
    logic       mRdy;

    shift_register_if #(.width(8)) bus ();

    shift_register #(.width(8)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the model's post-edge view, then wait past the edge.
    task automatic step(input logic rst, input logic stb, input logic stb8,
                        input logic load, input logic [7:0] pdin, input logic sin);
        @(negedge clk);
        resetN                 = rst;
        bus.peripheralClkEdge  = stb;
        bus.peripheralClk8Edge = stb8;
        bus.parallelLoad       = load;
        bus.parallelDataIn     = pdin;
        bus.serialDataIn       = sin;
        if (!rst) begin
            mMem = 8'h00; mCnt = 4'd0; mRdy = 1'b0;
        end else if (!stb) begin
            mRdy = 1'b0;
        end else if (load) begin
            mMem = pdin; mCnt = 4'd0; mRdy = 1'b0;
        end else begin
            mMem = {mMem[6:0], sin};
            mRdy = 1'b0;
            if (stb8) mCnt = 4'd1;
            else if (mCnt == 4'd7) begin mCnt = 4'd0; mRdy = 1'b1; end
            else mCnt = mCnt + 4'd1;
        end
        sb.push_back('{mem: mMem, sout: mMem[7], rdy: mRdy});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, i[0], 8'hFF, 1'b1);
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
    endtask

    task automatic test_serial_fill;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, ~i[0]);
            else       step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (bus.wordReady === 1'b1) pulses++;
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL fill[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
        total++;
        if (bus.parallelDataOut !== 8'hAA || bus.serialDataOut !== 1'b1 || pulses != 1) begin
            bad++;
            $display("FAIL fill_final: got data=%h sout=%b pulses=%0d want data=aa sout=1 pulses=1",
                     bus.parallelDataOut, bus.serialDataOut, pulses);
        end
    endtask

    task automatic test_parallel_load;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1);
            else        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL load[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
        total++;
        if (bus.parallelDataOut !== 8'h4A || bus.serialDataOut !== 1'b0) begin
            bad++;
            $display("FAIL load_final: got data=%h sout=%b want data=4a sout=0",
                     bus.parallelDataOut, bus.serialDataOut);
        end
    endtask

    task automatic test_gating;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, i[1], 1'b1, 8'h3C, i[0]);
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL gate[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
        total++;
        if (bus.parallelDataOut !== 8'h4A) begin
            bad++;
            $display("FAIL gate_final: got data=%h want data=4a", bus.parallelDataOut);
        end
    endtask

    task automatic test_realign;
        int readyAt;
        readyAt = -1;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b1, (i == 3), 1'b0, 8'h00, i[0] ^ i[2]);
            if (bus.wordReady === 1'b1 && readyAt < 0) readyAt = i;
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL realign[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
        total++;
        if (readyAt != 10) begin
            bad++;
            $display("FAIL realign_pos: got first pulse at step %0d want step 10", readyAt);
        end
    endtask

    task automatic test_mid_reset;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 0)      step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
            else if (i < 4)  step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            else if (i == 4) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            else             step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            if (bus.wordReady === 1'b1) pulses++;
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL midreset[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
        total++;
        if (bus.parallelDataOut !== 8'hFF || bus.wordReady !== 1'b1 || pulses != 1) begin
            bad++;
            $display("FAIL midreset_final: got data=%h rdy=%b pulses=%0d want data=ff rdy=1 pulses=1",
                     bus.parallelDataOut, bus.wordReady, pulses);
        end
    endtask

    task automatic test_back_to_back;
        logic stb, stb8, load;
        for (int i = 0; i < 60; i++) begin
            stb  = ($urandom_range(0, 3) != 0);
            stb8 = ($urandom_range(0, 9) == 0);
            load = ($urandom_range(0, 11) == 0);
            step(1'b1, stb, stb8, load, 8'($urandom), 1'($urandom));
            e = sb.pop_front();
            total++;
            if ({bus.parallelDataOut, bus.serialDataOut, bus.wordReady} !== e) begin
                bad++;
                $display("FAIL b2b[%0d]: got data=%h sout=%b rdy=%b want data=%h sout=%b rdy=%b",
                         i, bus.parallelDataOut, bus.serialDataOut, bus.wordReady, e.mem, e.sout, e.rdy);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mMem  = 8'h00;
        mCnt  = 4'd0;
        mRdy  = 1'b0;
        resetN                 = 1'b0;
        bus.peripheralClkEdge  = 1'b0;
        bus.peripheralClk8Edge = 1'b0;
        bus.parallelLoad       = 1'b0;
        bus.parallelDataIn     = 8'h00;
        bus.serialDataIn       = 1'b0;
        test_reset();
        test_serial_fill();
        test_parallel_load();
        test_gating();
        test_realign();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
